extend: RTL and testbench

- Registered sign/zero extender: widens an IN_W-bit immediate to an OUT_W-bit datapath word, one clock of latency.
- Sits between instruction decode (immediate field) and the ALU/address operand mux.
- Default configuration extends 8 bits to 20 bits.

---
 rtl/extend.sv | 99 +++++++++
 tb/tb_extend.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/extend.sv
// -----------------------------------------------------------------------------
// extend -- registered sign/zero extender
//
// Widens an IN_W-bit immediate to an OUT_W-bit datapath word, with one clock
// of latency. It sits between the instruction decode immediate field and the
// ALU/address operand mux.
//
// Parameters:
//   IN_W   width of the input immediate (>= 1)
//   OUT_W  width of the extended result (> IN_W)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high; overrides in_valid
//   unextended  in   [IN_W-1:0]  immediate to extend
//   in_valid    in   capture strobe
//   zero_ext    in   0 = sign-extend, 1 = zero-extend
//   extended    out  [OUT_W-1:0] registered extended value
//   out_valid   out  high for one cycle after each capture
//   is_neg      out  registered extended[OUT_W-1]   (EXTEND_STATUS_EN only)
//   is_zero     out  registered (extended == 0)     (EXTEND_STATUS_EN only)
//
// Optional feature macro: EXTEND_STATUS_EN adds the is_neg / is_zero outputs.
//
// Handshake: there is no back-pressure. unextended and zero_ext are sampled
// on every rising edge where in_valid is high and rst is low; the result
// appears on extended with out_valid high for exactly the following cycle.
// With in_valid low, extended holds its last value and out_valid drops, so
// back-to-back strobes yield one result per cycle.
// -----------------------------------------------------------------------------
module extend #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  unextended,
   input  logic             in_valid,
   input  logic             zero_ext,
`ifdef EXTEND_STATUS_EN
   output logic             is_neg,
   output logic             is_zero,
`endif
   output logic [OUT_W-1:0] extended,
   output logic             out_valid
);

   // Reject configurations that cannot produce a wider word.
   generate
      if (IN_W < 1) begin : g_bad_in_w
         $error("extend: IN_W must be at least 1");
      end
      if (OUT_W <= IN_W) begin : g_bad_out_w
         $error("extend: OUT_W must be greater than IN_W");
      end
   endgenerate

   localparam int EXT_W = OUT_W - IN_W;

   // Bit replicated into the upper field: the input MSB in sign mode,
   // zero in zero-extend mode.
   logic             fill;
   logic [OUT_W-1:0] ext_next;

   always_comb begin
      fill     = ~zero_ext & unextended[IN_W-1];
      ext_next = {{EXT_W{fill}}, unextended};
   end

   // Only the capture path reads unextended, so X/Z on the input while
   // in_valid is low never reaches the register.
   always_ff @(posedge clk) begin
      if (rst) begin
         extended  <= '0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         extended  <= ext_next;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

`ifdef EXTEND_STATUS_EN
   // Flags are computed from the value being captured so they line up with
   // extended on the same edge. is_zero resets to 0 even though extended
   // resets to zero: the flags describe captured results only.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_neg  <= 1'b0;
         is_zero <= 1'b0;
      end else if (in_valid) begin
         is_neg  <= ext_next[OUT_W-1];
         is_zero <= (ext_next == '0);
      end
   end
`endif

endmodule

// File: tb/tb_extend.sv
// -----------------------------------------------------------------------------
// tb_extend -- directed self-checking bench for extend (IN_W=8, OUT_W=20).
// Inputs change 1 ns after each rising edge; outputs are checked 1 ns after
// the edge that should have produced them. When built with EXTEND_STATUS_EN
// the is_neg / is_zero outputs are checked as well.
// -----------------------------------------------------------------------------
module tb_extend;

   localparam int IN_W  = 8;
   localparam int OUT_W = 20;

   logic             clk;
   logic             rst;
   logic [IN_W-1:0]  unextended;
   logic             in_valid;
   logic             zero_ext;
   logic [OUT_W-1:0] extended;
   logic             out_valid;
`ifdef EXTEND_STATUS_EN
   logic             is_neg;
   logic             is_zero;
`endif

   int total;
   int bad;

   extend #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .unextended (unextended),
      .in_valid   (in_valid),
      .zero_ext   (zero_ext),
`ifdef EXTEND_STATUS_EN
      .is_neg     (is_neg),
      .is_zero    (is_zero),
`endif
      .extended   (extended),
      .out_valid  (out_valid)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst        = 1'b1;
      in_valid   = 1'b1;
      zero_ext   = 1'b0;
      unextended = 8'h55;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (extended !== 20'h00000) begin
            bad++;
            $display("FAIL reset_ext edge%0d: got %h want 00000", i, extended);
         end
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid edge%0d: got %b want 0", i, out_valid);
         end
`ifdef EXTEND_STATUS_EN
         total++;
         if (is_neg !== 1'b0 || is_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags edge%0d: got neg=%b zero=%b want 0 0", i, is_neg, is_zero);
         end
`endif
      end
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_sign_pos();
      unextended = 8'h0C;
      zero_ext   = 1'b0;
      in_valid   = 1'b1;
      // No combinational path: output must not move before the edge.
      #1;
      total++;
      if (extended !== 20'h00000) begin
         bad++;
         $display("FAIL pre_edge_ext: got %h want 00000", extended);
      end
      tick();
      total++;
      if (extended !== 20'h0000C || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL sign_pos: got %h v=%b want 0000c v=1", extended, out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_sign_neg();
      unextended = 8'hEC;
      zero_ext   = 1'b0;
      in_valid   = 1'b1;
      tick();
      total++;
      if (extended !== 20'hFFFEC || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL sign_neg: got %h v=%b want fffec v=1", extended, out_valid);
      end
      zero_ext = 1'b1;
      tick();
      total++;
      if (extended !== 20'h000EC || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL zero_ext_neg: got %h v=%b want 000ec v=1", extended, out_valid);
      end
      in_valid = 1'b0;
      zero_ext = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [IN_W-1:0]  vin  [4];
      logic [OUT_W-1:0] vexp [4];
      vin[0] = 8'h7F; vexp[0] = 20'h0007F;
      vin[1] = 8'h80; vexp[1] = 20'hFFF80;
      vin[2] = 8'hFF; vexp[2] = 20'hFFFFF;
      vin[3] = 8'h00; vexp[3] = 20'h00000;
      zero_ext = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         unextended = vin[i];
         tick();
         total++;
         if (extended !== vexp[i]) begin
            bad++;
            $display("FAIL b2b_ext[%0d]: got %h want %h", i, extended, vexp[i]);
         end
         total++;
         if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid);
         end
`ifdef EXTEND_STATUS_EN
         total++;
         if (is_neg !== vexp[i][OUT_W-1] || is_zero !== (i == 3)) begin
            bad++;
            $display("FAIL b2b_flags[%0d]: got neg=%b zero=%b", i, is_neg, is_zero);
         end
`endif
      end
      in_valid = 1'b0;
   endtask

   task automatic test_hold();
      logic [IN_W-1:0] toggles [4];
      toggles[0] = 8'h0F;
      toggles[1] = 8'h24;
      toggles[2] = 8'h0F;
      toggles[3] = 'x;
      unextended = 8'h2D;
      zero_ext   = 1'b0;
      in_valid   = 1'b1;
      tick();
      total++;
      if (extended !== 20'h0002D || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL hold_capture: got %h v=%b want 0002d v=1", extended, out_valid);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         unextended = toggles[i];
         zero_ext   = i[0];
         tick();
         total++;
         if (extended !== 20'h0002D) begin
            bad++;
            $display("FAIL hold_ext[%0d]: got %h want 0002d", i, extended);
         end
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_valid[%0d]: got %b want 0", i, out_valid);
         end
`ifdef EXTEND_STATUS_EN
         total++;
         if (is_neg !== 1'b0 || is_zero !== 1'b0) begin
            bad++;
            $display("FAIL hold_flags[%0d]: got neg=%b zero=%b want 0 0", i, is_neg, is_zero);
         end
`endif
      end
      zero_ext = 1'b0;
   endtask

   task automatic test_midstream_reset();
      unextended = 8'h80;
      zero_ext   = 1'b0;
      in_valid   = 1'b1;
      tick();
      total++;
      if (extended !== 20'hFFF80 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_capture: got %h v=%b want fff80 v=1", extended, out_valid);
      end
`ifdef EXTEND_STATUS_EN
      total++;
      if (is_neg !== 1'b1 || is_zero !== 1'b0) begin
         bad++;
         $display("FAIL mid_flags: got neg=%b zero=%b want 1 0", is_neg, is_zero);
      end
`endif
      rst        = 1'b1;
      unextended = 8'h11;
      tick();
      total++;
      if (extended !== 20'h00000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got %h v=%b want 00000 v=0", extended, out_valid);
      end
`ifdef EXTEND_STATUS_EN
      total++;
      if (is_neg !== 1'b0 || is_zero !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_flags: got neg=%b zero=%b want 0 0", is_neg, is_zero);
      end
`endif
      // Pending input was discarded: one idle edge keeps the cleared value.
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      total++;
      if (extended !== 20'h00000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: got %h v=%b want 00000 v=0", extended, out_valid);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      zero_ext   = 1'b0;
      unextended = '0;
      #1;
      test_reset();
      test_sign_pos();
      test_sign_neg();
      test_back_to_back();
      test_hold();
      test_midstream_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
